// File: rtl/dmem_mmio_responder.sv
// Memory-side responder on the dmem port: a 4-word MMIO window with cycle counter, TX byte FIFO,
// status and scratch. Read data is registered one cycle after the address, like the dmem syncram.
module dmem_mmio_responder #(
  parameter logic [11:0] BASE_ADDR  = 12'hFF0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_mmio,
  output logic        hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic             sel;
  logic [1:0]       off;
  logic             wr_cycle, wr_status, wr_scratch;
  logic             push, pop, push_ok, ovf_set;
  logic             full, empty, overflow;
  logic [31:0]      cycle_cnt, scratch;
  logic [31:0]      rd_data_p0, rd_data_p1;
  logic             vld_p1;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [4:0]       cnt5;

  assign sel        = (address[11:2] == BASE_ADDR[11:2]);
  assign off        = address[1:0];
  assign wr_cycle   = sel && wren && (off == 2'd0);
  assign push       = sel && wren && (off == 2'd1);
  assign wr_status  = sel && wren && (off == 2'd2);
  assign wr_scratch = sel && wren && (off == 2'd3);

  assign full     = (fifo_cnt == DEPTH_C);
  assign empty    = (fifo_cnt == '0);
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop      = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
  assign push_ok  = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign cnt5     = 5'(fifo_cnt);

  always_comb begin
    rd_data_p0 = 32'h0;
    if (sel) begin
      case (off)
        2'd0:    rd_data_p0 = cycle_cnt;
        2'd2:    rd_data_p0 = {22'b0, cnt5, 2'b00, overflow, full, empty};
        2'd3:    rd_data_p0 = scratch;
        default: rd_data_p0 = 32'h0;
      endcase
    end
  end

  // p0 -> p1: read data and hit registered; all register state updates on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_p1 <= 32'h0;
      vld_p1     <= 1'b0;
      cycle_cnt  <= 32'h0;
      scratch    <= 32'h0;
      overflow   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      rd_data_p1 <= rd_data_p0;
      vld_p1     <= sel;
      cycle_cnt  <= wr_cycle ? 32'h0 : cycle_cnt + 32'd1;
      if (wr_scratch) scratch <= data;
      if (ovf_set) overflow <= 1'b1;
      else if (wr_status && data[2]) overflow <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push_ok && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= data[7:0];
  end

  assign q_mmio = rd_data_p1;
  assign hit    = vld_p1;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: vector table, directed FIFO/counter/reset sequences, randomized model run.
module tb_dmem_mmio_responder;
  localparam logic [11:0] BASE  = 12'hFF0;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] address = 12'h0;
  logic [31:0] data = 32'h0;
  logic        wren = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] q_mmio;
  logic        hit;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int n_pass  = 0;
  int n_total = 0;

  dmem_mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data), .wren(wren),
    .q_mmio(q_mmio), .hit(hit), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_q;
    logic        exp_hit;
    logic        chk_q;
  } vec_t;

  vec_t vecs [13];

  // behavioural reference state for the randomized run
  logic [31:0] m_cycle, m_scratch;
  logic        m_ovf;
  logic [7:0]  m_fifo [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
    address  = a;
    data     = d;
    wren     = w;
    tx_ready = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] q1, q2, eq;
    logic [11:0] a;
    logic [31:0] d;
    logic        w, r, s, pop_m, push_m;
    logic [1:0]  o;
    int          sz;

    vecs[0]  = '{12'hFF3, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b1};
    vecs[1]  = '{12'hFF3, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[2]  = '{12'h000, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
    vecs[3]  = '{12'hFF1, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1};
    vecs[4]  = '{12'hFF2, 32'h0,        1'b0, 32'h1,        1'b1, 1'b1};
    vecs[5]  = '{12'h000, 32'h5,        1'b1, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{12'hFF3, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[7]  = '{12'hFF0, 32'h1234,     1'b1, 32'h0,        1'b1, 1'b0};
    vecs[8]  = '{12'hFF0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1};
    vecs[9]  = '{12'hFF0, 32'h0,        1'b0, 32'h1,        1'b1, 1'b1};
    vecs[10] = '{12'hFF2, 32'h4,        1'b1, 32'h1,        1'b1, 1'b1};
    vecs[11] = '{12'hFF4, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
    vecs[12] = '{12'hFEF, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};

    #22;
    chk("rst.q_mmio", q_mmio, 32'h0);
    chk("rst.hit", 32'(hit), 32'h0);
    chk("rst.tx_valid", 32'(tx_valid), 32'h0);
    chk("rst.tx_data", 32'(tx_data), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // cycle counter advances by exactly 10 over 10 clocks
    cyc(12'hFF0, 32'h0, 1'b0, 1'b0);
    q1 = q_mmio;
    chk("cyc.hit1", 32'(hit), 32'h1);
    repeat (9) cyc(12'h000, 32'h0, 1'b0, 1'b0);
    cyc(12'hFF0, 32'h0, 1'b0, 1'b0);
    q2 = q_mmio;
    chk("cyc.hit2", 32'(hit), 32'h1);
    chk("cyc.delta", q2 - q1, 32'd10);

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0);
      chk($sformatf("vec%0d.hit", i), 32'(hit), 32'(vecs[i].exp_hit));
      if (vecs[i].chk_q) chk($sformatf("vec%0d.q", i), q_mmio, vecs[i].exp_q);
    end

    // fill the FIFO, overflow it, clear overflow
    for (int i = 0; i < 8; i++) begin
      cyc(12'hFF1, 32'hABCDEF00 | 32'(8'h41 + i), 1'b1, 1'b0);
      if (i == 0) begin
        chk("fifo.first_valid", 32'(tx_valid), 32'h1);
        chk("fifo.first_data", 32'(tx_data), 32'h41);
      end
    end
    cyc(12'hFF2, 32'h0, 1'b0, 1'b0);
    chk("fifo.status_full", q_mmio, 32'h0000_0102);
    cyc(12'hFF1, 32'h49, 1'b1, 1'b0);
    cyc(12'hFF2, 32'h0, 1'b0, 1'b0);
    chk("fifo.status_ovf", q_mmio, 32'h0000_0106);
    chk("fifo.head_kept", 32'(tx_data), 32'h41);
    cyc(12'hFF2, 32'h4, 1'b1, 1'b0);
    chk("fifo.w1c_rbw", q_mmio, 32'h0000_0106);
    cyc(12'hFF2, 32'h0, 1'b0, 1'b0);
    chk("fifo.status_clr", q_mmio, 32'h0000_0102);

    // push while full with a simultaneous pop is accepted
    cyc(12'hFF1, 32'h50, 1'b1, 1'b1);
    cyc(12'hFF2, 32'h0, 1'b0, 1'b0);
    chk("fifo.pushpop_status", q_mmio, 32'h0000_0102);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.valid", i), 32'(tx_valid), 32'h1);
      chk($sformatf("drain%0d.data", i), 32'(tx_data), (i == 7) ? 32'h50 : 32'(8'h42 + i));
      cyc(12'h000, 32'h0, 1'b0, 1'b1);
    end
    chk("drain.valid_low", 32'(tx_valid), 32'h0);
    chk("drain.data_zero", 32'(tx_data), 32'h0);
    cyc(12'hFF2, 32'h0, 1'b0, 1'b0);
    chk("drain.status", q_mmio, 32'h1);

    // counter wrap and write-wins-over-increment
    cyc(12'hFF0, 32'h0, 1'b1, 1'b0);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    address = 12'hFF0;
    wren    = 1'b0;
    @(posedge clock);
    #1;
    chk("wrap.max", q_mmio, 32'hFFFF_FFFF);
    cyc(12'hFF0, 32'h0, 1'b0, 1'b0);
    chk("wrap.zero", q_mmio, 32'h0);
    cyc(12'hFF0, 32'h77, 1'b1, 1'b0);
    cyc(12'hFF0, 32'h0, 1'b0, 1'b0);
    chk("cycwr.zero", q_mmio, 32'h0);

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 5; i++) cyc(12'hFF1, 32'(8'h60 + i), 1'b1, 1'b0);
    cyc(12'h000, 32'h0, 1'b0, 1'b1);
    cyc(12'h000, 32'h0, 1'b0, 1'b1);
    cyc(12'hFF2, 32'h0, 1'b0, 1'b0);
    chk("mid.status_cnt3", q_mmio, 32'h0000_0060);
    chk("mid.head", 32'(tx_data), 32'h62);
    tx_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid.tx_valid", 32'(tx_valid), 32'h0);
    chk("mid.q_mmio", q_mmio, 32'h0);
    chk("mid.hit", 32'(hit), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    cyc(12'hFF2, 32'h0, 1'b0, 1'b0);
    chk("post.status", q_mmio, 32'h1);
    chk("post.hit", 32'(hit), 32'h1);

    // randomized run against the reference model, from a fresh reset
    reset = 1'b0;
    #1;
    @(negedge clock);
    reset     = 1'b1;
    m_cycle   = 32'h0;
    m_scratch = 32'h0;
    m_ovf     = 1'b0;
    m_fifo.delete();
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) != 0) ? (BASE | 12'($urandom_range(0, 3))) : 12'($urandom_range(0, 4095));
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      r = (i < 150) ? 1'b0 : 1'($urandom_range(0, 1));
      s = ((a >> 2) == (BASE >> 2));
      o = a[1:0];
      sz = m_fifo.size();
      eq = 32'h0;
      if (s) begin
        case (o)
          2'd0:    eq = m_cycle;
          2'd2:    eq = {22'b0, 5'(sz), 2'b00, m_ovf, (sz == DEPTH), (sz == 0)};
          2'd3:    eq = m_scratch;
          default: eq = 32'h0;
        endcase
      end
      pop_m  = (sz > 0) && r;
      push_m = s && w && (o == 2'd1);
      if (pop_m) void'(m_fifo.pop_front());
      if (push_m) begin
        if (sz == DEPTH && !pop_m) m_ovf = 1'b1;
        else m_fifo.push_back(d[7:0]);
      end
      if (s && w && o == 2'd0) m_cycle = 32'h0;
      else m_cycle = m_cycle + 32'd1;
      if (s && w && o == 2'd3) m_scratch = d;
      if (s && w && o == 2'd2 && d[2]) m_ovf = 1'b0;
      cyc(a, d, w, r);
      chk($sformatf("rnd%0d.q", i), q_mmio, eq);
      chk($sformatf("rnd%0d.hit", i), 32'(hit), 32'(s));
      chk($sformatf("rnd%0d.valid", i), 32'(tx_valid), 32'(m_fifo.size() > 0));
      chk($sformatf("rnd%0d.data", i), 32'(tx_data), (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
